fir_filter: RTL and testbench

Parametrised, streaming, symmetric FIR filter that replaces the fixed-delay shift-register stand-in in the projection filtering path. It convolves each projection line of `pLineLength` samples with a run-time-loaded linear-phase kernel. It compensates the group delay and zero-pads both line edges, so every input line yields exactly `pLineLength` centred ("same") outputs. It sits between the projection sample source and the back-projection line buffers, with valid/ready handshakes on both sides.

---
 rtl/fir_filter.sv | 220 ++++++++++++++++++++++
 tb/tb_fir_filter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
// Streaming symmetric (linear-phase) FIR filter: each line of pLineLength samples yields
// pLineLength centred outputs, with the group delay absorbed by zero-padding both line edges.
module fir_filter #(
    parameter int pDataLength         = 12,
    parameter int pCoeffLength        = 12,
    parameter int pFilteredDataLength = 16,
    parameter int pOrder              = 8,
    parameter int pLineLength         = 128,
    parameter int pShift              = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [pDataLength-1:0]            in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [pFilteredDataLength-1:0]    out_data,
    output logic                              out_last,
    input  logic                              coef_we,
    input  logic [$clog2(pOrder/2+1)-1:0]     coef_addr,
    input  logic [pCoeffLength-1:0]           coef_data,
    output logic                              busy,
    output logic                              saturated
);

    localparam int D   = pOrder / 2;
    localparam int CAW = $clog2(D + 1);
    localparam int PW  = pDataLength + 1;
    localparam int PRW = PW + pCoeffLength;
    localparam int AW  = PRW + $clog2(D + 1);
    localparam int FW  = pFilteredDataLength;
    localparam int SW  = $clog2(pLineLength + D + 1);

    localparam logic [SW-1:0] S_LAST_IN = SW'(pLineLength - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(pLineLength + D - 1);
    localparam logic [SW-1:0] S_CENTRE  = SW'(D);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-FW+1){1'b0}}, {(FW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-FW+1){1'b1}}, {(FW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 s_q, s_d;
    logic                          wv_q, wv_d;
    logic                          wlast_q, wlast_d;
    logic signed [pDataLength-1:0] w_q [0:pOrder];
    logic signed [pCoeffLength-1:0] h_q [0:D];

    logic                          free_s, allow_s, step_s;
    logic signed [PW-1:0]          pre_s;
    logic signed [PRW-1:0]         prod_s;
    logic signed [AW-1:0]          acc_s, shifted_s;
    logic                          sat_s;
    logic [FW-1:0]                 y_s;

    assign free_s  = !out_valid || out_ready;
    assign allow_s = !wv_q || free_s;
    assign busy    = (state_q != IDLE) || wv_q || out_valid;

    // Line sequencer: step index, window-valid tracking and state transitions
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        wv_d     = wv_q;
        wlast_d  = wlast_q;
        step_s   = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = allow_s;
                step_s   = in_valid && allow_s;
                if (step_s) begin
                    s_d     = SW'(1);
                    state_d = (pLineLength == 1) ? DRAIN : LOAD;
                end else begin
                    s_d = s_q;
                end
            end
            LOAD: begin
                in_ready = allow_s;
                step_s   = in_valid && allow_s;
                if (step_s) begin
                    s_d     = s_q + SW'(1);
                    state_d = (s_q == S_LAST_IN) ? DRAIN : LOAD;
                end else begin
                    s_d = s_q;
                end
            end
            DRAIN: begin
                step_s = allow_s;
                if (step_s && (s_q == S_LAST)) begin
                    s_d     = '0;
                    state_d = IDLE;
                end else if (step_s) begin
                    s_d = s_q + SW'(1);
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
        // Steps before the centre tap reaches x[0] only fill the window.
        if (step_s) begin
            wv_d    = (s_q >= S_CENTRE);
            wlast_d = (s_q == S_LAST);
        end else if (wv_q && free_s) begin
            wv_d    = 1'b0;
            wlast_d = 1'b0;
        end else begin
            wv_d    = wv_q;
            wlast_d = wlast_q;
        end
        if (clear) begin
            state_d = IDLE;
            s_d     = '0;
            wv_d    = 1'b0;
            wlast_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Folded symmetric MAC in full precision, then floor shift and saturation
    always_comb begin
        acc_s  = '0;
        pre_s  = '0;
        prod_s = '0;
        for (int k = 0; k < D; k++) begin
            pre_s  = PW'(w_q[k]) + PW'(w_q[pOrder-k]);
            prod_s = PRW'(pre_s) * PRW'(h_q[k]);
            acc_s  = acc_s + AW'(prod_s);
        end
        pre_s     = PW'(w_q[D]);
        prod_s    = PRW'(pre_s) * PRW'(h_q[D]);
        acc_s     = acc_s + AW'(prod_s);
        shifted_s = acc_s >>> pShift;
        if (shifted_s > SAT_MAX) begin
            sat_s = 1'b1;
            y_s   = SAT_MAX[FW-1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = 1'b1;
            y_s   = SAT_MIN[FW-1:0];
        end else begin
            sat_s = 1'b0;
            y_s   = shifted_s[FW-1:0];
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            wv_q    <= 1'b0;
            wlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            wv_q    <= wv_d;
            wlast_q <= wlast_d;
        end
    end

    // Sample window; a new line starts with zeros behind its first sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= pOrder; i++) w_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i <= pOrder; i++) w_q[i] <= '0;
        end else if (step_s) begin
            w_q[0] <= (state_q == DRAIN) ? '0 : in_data;
            for (int i = 1; i <= pOrder; i++) w_q[i] <= (state_q == IDLE) ? '0 : w_q[i-1];
        end
    end

    // Coefficient store, deliberately untouched by clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= D; k++) h_q[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k <= D; k++) begin
                if (coef_addr == CAW'(k)) h_q[k] <= coef_data;
            end
        end
    end

    // Output register stage and sticky saturation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            saturated <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            saturated <= 1'b0;
        end else if (free_s) begin
            out_valid <= wv_q;
            if (wv_q) begin
                out_data <= y_s;
                out_last <= wlast_q;
                if (sat_s) saturated <= 1'b1;
            end else begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter (order 8, line length 16, no output shift):
// directed tables, a line-level convolution reference model, and randomized lines.
module tb_fir_filter;

    localparam int DL  = 12;
    localparam int CL  = 12;
    localparam int FL  = 16;
    localparam int ORD = 8;
    localparam int D   = ORD / 2;
    localparam int L   = 16;
    localparam int SH  = 0;

    typedef struct {
        string  name;
        int     line;
        int     n;
        longint exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n, clear, in_valid, in_ready, out_valid, out_ready, out_last;
    logic          coef_we, busy, saturated;
    logic [DL-1:0] in_data;
    logic [FL-1:0] out_data;
    logic [2:0]    coef_addr;
    logic [CL-1:0] coef_data;

    fir_filter #(
        .pDataLength(DL), .pCoeffLength(CL), .pFilteredDataLength(FL),
        .pOrder(ORD), .pLineLength(L), .pShift(SH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .saturated(saturated)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc = 0;
    int     stall_acc = 0;
    int     max_stall = 0;
    longint cap_data[$];
    bit     cap_last[$];
    int     cap_cyc[$];
    int     acc_cyc[$];
    int     stim[$];
    int     h_cur[D+1];
    int     xl[L];
    bit     bp_mode = 1'b0;

    // Observe handshakes mid-cycle, away from the active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            cap_data.push_back(longint'($signed(out_data)));
            cap_last.push_back(out_last);
            cap_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (out_valid && !out_ready) begin
            if (in_valid && in_ready) begin
                stall_acc <= stall_acc + 1;
                if (stall_acc + 1 > max_stall) max_stall <= stall_acc + 1;
            end
        end else begin
            stall_acc <= 0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_coefs();
        for (int k = 0; k <= D; k++) begin
            coef_we   = 1'b1;
            coef_addr = 3'(k);
            coef_data = 12'(h_cur[k]);
            tick();
        end
        coef_we = 1'b0;
        tick();
    endtask

    task automatic send(input bit gap);
        bit ok;
        int budget;
        foreach (stim[i]) begin
            if (gap && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            in_valid = 1'b1;
            in_data  = 12'(stim[i]);
            ok = 1'b0;
            budget = 0;
            while (!ok && budget < 200) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!ok) check("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int budget;
        budget = 0;
        while (cap_data.size() < n && budget < 500) begin
            tick();
            budget++;
        end
        if (cap_data.size() < n) check("out_timeout", cap_data.size(), n);
    endtask

    // "Same"-mode convolution of the current line with the full symmetric kernel
    function automatic longint ref_out(input int n);
        longint acc;
        int     idx, hj;
        acc = 0;
        for (int j = 0; j <= ORD; j++) begin
            idx = n + D - j;
            hj  = (j <= D) ? h_cur[j] : h_cur[ORD-j];
            if (idx >= 0 && idx < L) acc += longint'(hj) * longint'(xl[idx]);
        end
        acc = acc >>> SH;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic check_line(input string tag, input int base);
        for (int i = 0; i < L; i++) begin
            if (base + i < cap_data.size()) begin
                check($sformatf("%s_y%0d", tag, i), cap_data[base+i], ref_out(i));
                check($sformatf("%s_last%0d", tag, i), longint'(cap_last[base+i]), longint'(i == L - 1));
            end
        end
    endtask

    task automatic check_table(input vec_t tbl[32], input int line, input int base);
        for (int t = 0; t < 32; t++) begin
            if (tbl[t].line == line && base + tbl[t].n < cap_data.size())
                check(tbl[t].name, cap_data[base+tbl[t].n], tbl[t].exp);
        end
    endtask

    initial begin
        vec_t tbl[32];
        int   imp_exp[16];
        int   pad_exp[16];
        int   base, abase;

        imp_exp = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
        pad_exp = '{500, 600, 700, 800, 900, 900, 900, 900,
                    900, 900, 900, 900, 800, 700, 600, 500};
        for (int i = 0; i < 16; i++) begin
            tbl[i]    = '{$sformatf("tbl_imp_y%0d", i), 0, i, longint'(imp_exp[i])};
            tbl[16+i] = '{$sformatf("tbl_pad_y%0d", i), 1, i, longint'(pad_exp[i])};
        end

        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_saturated", saturated, 0);
        check("rst_in_ready", in_ready, 1);
        tick();

        // Impulse response and latency
        h_cur = '{1, 2, 3, 4, 5};
        load_coefs();
        for (int i = 0; i < L; i++) xl[i] = (i == 5) ? 1 : 0;
        stim = {};
        for (int i = 0; i < L; i++) stim.push_back(xl[i]);
        base = cap_data.size(); abase = acc_cyc.size();
        send(1'b0);
        wait_out(base + L);
        check_table(tbl, 0, base);
        check_line("imp", base);
        if (cap_cyc.size() > base && acc_cyc.size() > abase + 4)
            check("imp_latency", cap_cyc[base] - acc_cyc[abase+4], 2);

        // Edge padding
        h_cur = '{1, 1, 1, 1, 1};
        load_coefs();
        for (int i = 0; i < L; i++) xl[i] = 100;
        stim = {};
        for (int i = 0; i < L; i++) stim.push_back(100);
        base = cap_data.size();
        send(1'b0);
        wait_out(base + L);
        check_table(tbl, 1, base);

        // Same stimulus under random backpressure and gapped input
        bp_mode = 1'b1;
        base = cap_data.size();
        send(1'b1);
        wait_out(base + L);
        bp_mode = 1'b0;
        repeat (3) tick();
        check_table(tbl, 1, base);
        check_line("bp", base);
        check("bp_accepts_during_stall_le1", longint'(max_stall <= 1), 1);

        // Saturation both ways, then clear drops the sticky flag
        h_cur = '{2047, 2047, 2047, 2047, 2047};
        load_coefs();
        for (int i = 0; i < L; i++) xl[i] = 2047;
        stim = {};
        for (int i = 0; i < L; i++) stim.push_back(2047);
        base = cap_data.size();
        send(1'b0);
        wait_out(base + L);
        check_line("satp", base);
        check("satp_flag", saturated, 1);
        for (int i = 0; i < L; i++) xl[i] = -2048;
        stim = {};
        for (int i = 0; i < L; i++) stim.push_back(-2048);
        base = cap_data.size();
        send(1'b0);
        wait_out(base + L);
        check_line("satn", base);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("clear_saturated", saturated, 0);
        tick();

        // Back-to-back lines: impulse at the last sample, then an all-zero line
        h_cur = '{1, 2, 3, 4, 5};
        load_coefs();
        stim = {};
        for (int i = 0; i < 2 * L; i++) stim.push_back((i == L - 1) ? 1 : 0);
        base = cap_data.size(); abase = acc_cyc.size();
        send(1'b0);
        wait_out(base + 2 * L);
        for (int i = 0; i < L; i++) xl[i] = (i == L - 1) ? 1 : 0;
        check_line("b2b1", base);
        for (int i = 0; i < L; i++) xl[i] = 0;
        check_line("b2b2", base + L);
        if (acc_cyc.size() > abase + L) begin
            check("b2b_ready_low_cycles", acc_cyc[abase+L] - acc_cyc[abase+L-1] - 1, D);
            check("b2b_line_period", acc_cyc[abase+L] - acc_cyc[abase], L + D);
        end

        // Abort with clear at sample 7; coefficients must survive
        for (int i = 0; i < L; i++) xl[i] = (i == 5) ? 1 : 0;
        stim = {};
        for (int i = 0; i < 7; i++) stim.push_back(xl[i]);
        send(1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        tick();
        stim = {};
        for (int i = 0; i < L; i++) stim.push_back(xl[i]);
        base = cap_data.size();
        send(1'b0);
        wait_out(base + L);
        check_line("abort_next", base);

        // Asynchronous reset mid-line wipes coefficients too
        stim = {};
        for (int i = 0; i < 7; i++) stim.push_back(xl[i]);
        send(1'b0);
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        h_cur = '{0, 0, 0, 0, 0};
        stim = {};
        for (int i = 0; i < L; i++) stim.push_back(xl[i]);
        base = cap_data.size();
        send(1'b0);
        wait_out(base + L);
        check_line("post_reset", base);

        // Randomized kernels and lines against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k <= D; k++) h_cur[k] = $urandom_range(0, 127) - 64;
            load_coefs();
            for (int i = 0; i < L; i++) xl[i] = $urandom_range(0, 600) - 300;
            stim = {};
            for (int i = 0; i < L; i++) stim.push_back(xl[i]);
            bp_mode = (r != 0);
            base = cap_data.size();
            send(r == 2);
            wait_out(base + L);
            bp_mode = 1'b0;
            repeat (3) tick();
            check_line($sformatf("rnd%0d", r), base);
        end
        check("final_accepts_during_stall_le1", longint'(max_stall <= 1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
